// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for universal_shift_reg: operation request signals in,
// register contents and burst handshake out.
interface universal_shift_reg_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CW    = 4
);
  logic             en;
  logic [2:0]       op;
  logic             sin_lo;
  logic             sin_hi;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q;
  logic             sout_lo;
  logic             sout_hi;
  logic             busy;
  logic             done;

  modport master (
    output en, op, sin_lo, sin_hi, d, start, count,
    input  q, sout_lo, sout_hi, busy, done
  );

  modport slave (
    input  en, op, sin_lo, sin_hi, d, start, count,
    output q, sout_lo, sout_hi, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: per-cycle hold/shift/rotate/load/fill operations
// plus an automatic multi-step burst with busy/done handshake.
module universal_shift_reg #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned CW         = 4,
  parameter int unsigned RESET_ONES = 1
) (
  input logic                    clk,
  input logic                    clear,
  universal_shift_reg_if.slave   bus
);
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;
  localparam logic [2:0] OP_ZERO = 3'd6;
  localparam logic [2:0] OP_ONES = 3'd7;

  localparam logic [WIDTH-1:0] RESET_Q = (RESET_ONES != 0) ? {WIDTH{1'b1}} : WIDTH'(0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    remain;
  logic             busy_r;
  logic             done_r;

  // Next register value for one application of an operation code.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] code,
                                            input logic [WIDTH-1:0] cur,
                                            input logic lo,
                                            input logic hi,
                                            input logic [WIDTH-1:0] din);
    case (code)
      OP_SHL:  step = {cur[WIDTH-2:0], lo};
      OP_SHR:  step = {hi, cur[WIDTH-1:1]};
      OP_ROL:  step = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  step = {cur[0], cur[WIDTH-1:1]};
      OP_LOAD: step = din;
      OP_ZERO: step = {WIDTH{1'b0}};
      OP_ONES: step = {WIDTH{1'b1}};
      default: step = cur;
    endcase
  endfunction

  function automatic logic is_burst_op(input logic [2:0] code);
    is_burst_op = (code >= OP_SHL) && (code <= OP_ROR);
  endfunction

  always_ff @(posedge clk) begin
    if (!clear) begin
      state  <= IDLE;
      q_r    <= RESET_Q;
      op_r   <= OP_HOLD;
      remain <= CW'(0);
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        RUN: begin
          // Serial inputs are sampled live on every burst step.
          q_r    <= step(op_r, q_r, bus.sin_lo, bus.sin_hi, bus.d);
          remain <= remain - CW'(1);
          if (remain == CW'(1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          if (bus.start && is_burst_op(bus.op)) begin
            // A zero-length burst completes immediately without touching q.
            if (bus.count != CW'(0)) begin
              state  <= RUN;
              op_r   <= bus.op;
              remain <= bus.count;
              busy_r <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end else if (bus.en) begin
            q_r <= step(bus.op, q_r, bus.sin_lo, bus.sin_hi, bus.d);
          end
        end
      endcase
    end
  end

  assign bus.q       = q_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.sout_lo = q_r[0];
  assign bus.sout_hi = q_r[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: table-driven stimulus, expected
// {q,busy,done} pushed to a scoreboard queue and compared after each edge.
module tb_universal_shift_reg;
  logic clk;
  logic clear;

  universal_shift_reg_if #(.WIDTH(6), .CW(4)) bus ();
  universal_shift_reg_if #(.WIDTH(6), .CW(4)) bus0 ();

  universal_shift_reg #(.WIDTH(6), .CW(4), .RESET_ONES(1)) dut (
    .clk(clk), .clear(clear), .bus(bus)
  );
  universal_shift_reg #(.WIDTH(6), .CW(4), .RESET_ONES(0)) dut0 (
    .clk(clk), .clear(clear), .bus(bus0)
  );

  typedef struct packed {
    logic       clr;
    logic       en;
    logic [2:0] op;
    logic       sl;
    logic       sh;
    logic [5:0] d;
    logic       st;
    logic [3:0] cnt;
    logic [5:0] q;
    logic       busy;
    logic       done;
  } row_t;

  typedef struct packed {
    logic [5:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs and record the state expected after the next edge.
  task automatic apply(input row_t r);
    exp_t e;
    clear      = r.clr;
    bus.en     = r.en;
    bus.op     = r.op;
    bus.sin_lo = r.sl;
    bus.sin_hi = r.sh;
    bus.d      = r.d;
    bus.start  = r.st;
    bus.count  = r.cnt;
    e.q    = r.q;
    e.busy = r.busy;
    e.done = r.done;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t t[$];
    exp_t e;
    t = '{'{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3F, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL reset: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    checks++;
    if ({bus0.q, bus0.busy, bus0.done} !== 8'b000000_0_0) begin
      failures++;
      $display("FAIL reset_zeros: got q=%b busy=%b done=%b, want q=000000 busy=0 done=0",
               bus0.q, bus0.busy, bus0.done);
    end
  endtask

  task automatic test_shift_in();
    row_t t[$];
    exp_t e;
    t = '{'{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3E, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3C, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h38, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h30, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h20, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h00, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL shift_in[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
      if (i == 0) begin
        checks++;
        if ({bus.sout_hi, bus.sout_lo} !== 2'b10) begin
          failures++;
          $display("FAIL sout: got hi=%b lo=%b, want hi=1 lo=0", bus.sout_hi, bus.sout_lo);
        end
      end
    end
  endtask

  task automatic test_load_rotate();
    row_t t[$];
    exp_t e;
    t = '{'{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 6'h25, 1'b0, 4'd0, 6'h25, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h32, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h25, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL load_rotate[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_burst();
    row_t t[$];
    exp_t e;
    // Inputs during busy deliberately request a load/new burst; they must be ignored.
    t = '{'{1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h00, 1'b0, 1'b0},
          '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 6'h00, 1'b1, 4'd3, 6'h00, 1'b1, 1'b0},
          '{1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 6'h3F, 1'b1, 4'd7, 6'h01, 1'b1, 1'b0},
          '{1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 6'h3F, 1'b1, 4'd7, 6'h03, 1'b1, 1'b0},
          '{1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 6'h3F, 1'b1, 4'd7, 6'h07, 1'b0, 1'b1},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h07, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL burst[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$];
    exp_t e;
    // Second burst is started during the done cycle of the first.
    t = '{'{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 6'h00, 1'b1, 4'd2, 6'h07, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h03, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h01, 1'b0, 1'b1},
          '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 6'h00, 1'b1, 4'd1, 6'h01, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h02, 1'b0, 1'b1},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h02, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_boundary();
    row_t t[$];
    exp_t e;
    t = '{'{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 6'h00, 1'b1, 4'd0, 6'h02, 1'b0, 1'b1},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h02, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 6'h2A, 1'b1, 4'd3, 6'h2A, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 6'h00, 1'b1, 4'd3, 6'h2A, 1'b0, 1'b0},
          '{1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 6'h00, 1'b1, 4'd3, 6'h2A, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 6'h00, 1'b1, 4'd3, 6'h3F, 1'b0, 1'b0},
          '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 6'h2A, 1'b0, 4'd0, 6'h2A, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL boundary[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    row_t t[$];
    exp_t e;
    t = '{'{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 6'h00, 1'b1, 4'd5, 6'h2A, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h15, 1'b1, 1'b0},
          '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3F, 1'b0, 1'b0},
          '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 6'h00, 1'b1, 4'd2, 6'h3F, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3E, 1'b1, 1'b0},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3C, 1'b0, 1'b1},
          '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'h00, 1'b0, 4'd0, 6'h3C, 1'b0, 1'b0}};
    foreach (t[i]) begin
      apply(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done} !== e) begin
        failures++;
        $display("FAIL reset_mid_burst[%0d]: got q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 i, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  initial begin
    bus0.en = 1'b0; bus0.op = 3'd0; bus0.sin_lo = 1'b0; bus0.sin_hi = 1'b0;
    bus0.d = 6'h00; bus0.start = 1'b0; bus0.count = 4'd0;
    test_reset();
    test_shift_in();
    test_load_rotate();
    test_burst();
    test_back_to_back();
    test_boundary();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
